// File: rtl/fifo_rd_packer_if.sv
// rtl/fifo_rd_packer_if.sv - FIFO read port and packed beat stream bundle for fifo_rd_packer
//
// Purpose: groups the FIFO read handshake and the packed output stream into one bundle.
//   Optional flush/keep signals exist only when FIFO_RD_PACKER_FLUSH_EN is defined.
// Modports:
//   master - packer view: drives o_fifo_rden, o_data, o_valid, o_last (o_keep)
//   slave  - environment view: drives i_fifo_empty, i_fifo_rdata, i_ready (i_flush)
interface fifo_rd_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_NUM   = 4
);
    logic                           i_fifo_empty;
    logic                           o_fifo_rden;
    logic [DATA_WIDTH-1:0]          i_fifo_rdata;
    logic [DATA_WIDTH*PACK_NUM-1:0] o_data;
    logic                           o_valid;
    logic                           i_ready;
    logic                           o_last;
`ifdef FIFO_RD_PACKER_FLUSH_EN
    logic                           i_flush;
    logic [PACK_NUM-1:0]            o_keep;

    modport master (
        input  i_fifo_empty, i_fifo_rdata, i_ready, i_flush,
        output o_fifo_rden, o_data, o_valid, o_last, o_keep
    );
    modport slave (
        output i_fifo_empty, i_fifo_rdata, i_ready, i_flush,
        input  o_fifo_rden, o_data, o_valid, o_last, o_keep
    );
`else
    modport master (
        input  i_fifo_empty, i_fifo_rdata, i_ready,
        output o_fifo_rden, o_data, o_valid, o_last
    );
    modport slave (
        output i_fifo_empty, i_fifo_rdata, i_ready,
        input  o_fifo_rden, o_data, o_valid, o_last
    );
`endif
endinterface

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - pops FIFO words and packs PACK_NUM of them into framed wide beats
//
// Purpose: read-side consumer of an async FIFO (runs in the FIFO read clock). Pops words via
//   the FIFO's registered read port (data valid one cycle after rden), packs PACK_NUM words
//   into one beat (first word in the low bits) and presents it on a valid/ready stream.
//   o_last marks every BURST_LEN-th beat.
// Optional feature: macro FIFO_RD_PACKER_FLUSH_EN adds i_flush/o_keep and a flush FSM
//   (FILL -> DRAIN -> EMIT -> FILL) that emits a zero-padded partial beat with o_last set.
// Ports:
//   i_clk  - clock (FIFO read clock)
//   i_rst  - asynchronous reset, active-high
//   bus    - fifo_rd_packer_if.master: FIFO empty/rden/rdata, beat data/valid/ready/last
//            (plus flush/keep with the macro)
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_NUM   = 4,
    parameter int BURST_LEN  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    fifo_rd_packer_if.master  bus
);
    localparam int CW = $clog2(PACK_NUM + 1);
    localparam int IW = $clog2(PACK_NUM);
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(PACK_NUM);
    localparam logic [CW:0]   PN_EXT   = (CW + 1)'(PACK_NUM);
    localparam logic [BW-1:0] BEAT_MAX = BW'(BURST_LEN - 1);

`ifdef FIFO_RD_PACKER_FLUSH_EN
    typedef enum logic [1:0] {FILL = 2'd0, DRAIN = 2'd1, EMIT = 2'd2} state_t;
`else
    typedef enum logic {FILL = 1'b0} state_t;
`endif

    state_t                         state_q, state_d;
    logic [CW-1:0]                  count_q, count_d;
    logic                           inflight_q, inflight_d;
    logic [PACK_NUM-1:0][DATA_WIDTH-1:0] slots_q, slots_d;
    logic [DATA_WIDTH*PACK_NUM-1:0] data_q, data_d;
    logic                           valid_q, valid_d;
    logic                           last_q, last_d;
    logic [BW-1:0]                  beat_q, beat_d;
    logic                           rden;
    logic                           out_free;
    logic [CW:0]                    pending;
`ifdef FIFO_RD_PACKER_FLUSH_EN
    logic [PACK_NUM-1:0]            keep_q, keep_d;
    logic                           force_last_q, force_last_d;
`endif

    // Words already captured plus the one still on its way from the FIFO: issuing a read
    // only while this is below PACK_NUM guarantees a slot exists for every returned word.
    assign pending  = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign rden     = !i_rst && !bus.i_fifo_empty && (pending < PN_EXT) && (state_q == FILL);
    assign out_free = !valid_q || bus.i_ready;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        inflight_d = rden;
        slots_d    = slots_q;
        data_d     = data_q;
        valid_d    = valid_q;
        last_d     = last_q;
        beat_d     = beat_q;
`ifdef FIFO_RD_PACKER_FLUSH_EN
        keep_d       = keep_q;
        force_last_d = force_last_q;
`endif

        if (valid_q && bus.i_ready) begin
            valid_d = 1'b0;
        end

        if (inflight_q) begin
            slots_d[count_q[IW-1:0]] = bus.i_fifo_rdata;
            count_d                  = count_q + 1'b1;
        end

        case (state_q)
            FILL: begin
                // A complete pack either loads now or waits in the slots; a load on the
                // accept cycle overrides the valid clear above so the stream stays busy.
                if ((count_d == CNT_FULL) && out_free) begin
                    data_d  = slots_d;
                    valid_d = 1'b1;
                    last_d  = (beat_q == BEAT_MAX);
                    beat_d  = (beat_q == BEAT_MAX) ? '0 : beat_q + 1'b1;
                    count_d = '0;
`ifdef FIFO_RD_PACKER_FLUSH_EN
                    keep_d = '1;
                    if (force_last_q) begin
                        last_d       = 1'b1;
                        beat_d       = '0;
                        force_last_d = 1'b0;
                    end
`endif
                end
`ifdef FIFO_RD_PACKER_FLUSH_EN
                // Judge "pending" after this cycle's capture/load, counting a read just issued.
                if (bus.i_flush) begin
                    if ((count_d != '0) || rden) begin
                        state_d = DRAIN;
                    end else begin
                        force_last_d = 1'b1;
                    end
                end
`endif
            end
`ifdef FIFO_RD_PACKER_FLUSH_EN
            // No reads issue outside FILL, so at most one word lands here and DRAIN is one cycle.
            DRAIN: begin
                state_d = EMIT;
            end
            EMIT: begin
                if (out_free) begin
                    for (int k = 0; k < PACK_NUM; k++) begin
                        if (CW'(k) < count_q) begin
                            data_d[k*DATA_WIDTH +: DATA_WIDTH] = slots_q[k];
                            keep_d[k]                          = 1'b1;
                        end else begin
                            data_d[k*DATA_WIDTH +: DATA_WIDTH] = '0;
                            keep_d[k]                          = 1'b0;
                        end
                    end
                    valid_d      = 1'b1;
                    last_d       = 1'b1;
                    beat_d       = '0;
                    count_d      = '0;
                    force_last_d = 1'b0;
                    state_d      = FILL;
                end
            end
`endif
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= FILL;
            count_q    <= '0;
            inflight_q <= 1'b0;
            slots_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            beat_q     <= '0;
`ifdef FIFO_RD_PACKER_FLUSH_EN
            keep_q       <= '0;
            force_last_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            slots_q    <= slots_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            beat_q     <= beat_d;
`ifdef FIFO_RD_PACKER_FLUSH_EN
            keep_q       <= keep_d;
            force_last_q <= force_last_d;
`endif
        end
    end

    assign bus.o_fifo_rden = rden;
    assign bus.o_data      = data_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_last      = last_q;
`ifdef FIFO_RD_PACKER_FLUSH_EN
    assign bus.o_keep      = keep_q;
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - scoreboard bench for fifo_rd_packer
module tb_fifo_rd_packer;
    localparam int DW     = 8;
    localparam int PN     = 4;
    localparam int BL     = 16;
    localparam int BEAT_W = DW * PN;

    typedef struct {
        logic [BEAT_W-1:0] data;
        logic [PN-1:0]     keep;
        logic              last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_rd_packer_if #(.DATA_WIDTH(DW), .PACK_NUM(PN)) bus ();

    fifo_rd_packer #(.DATA_WIDTH(DW), .PACK_NUM(PN), .BURST_LEN(BL)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.master)
    );

    logic [DW-1:0] fifo_q[$];
    beat_t         exp_q[$];
    int            acc_cyc[$];
    int            n_vec = 0;
    int            n_bad = 0;
    int            cyc   = 0;

    beat_t             mon_b;
    logic              hold_v = 1'b0;
    logic [BEAT_W-1:0] hold_data;
    logic              hold_last;
    logic [PN-1:0]     hold_keep;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // FIFO model: registered read port, data valid the cycle after rden.
    initial begin
        bus.i_fifo_rdata = '0;
        forever begin
            @(posedge clk);
            if (bus.o_fifo_rden === 1'b1) begin
                if (fifo_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL fifo_underflow: rden=1 with model fifo empty, required rden=0");
                end else begin
                    bus.i_fifo_rdata <= fifo_q.pop_front();
                end
            end
        end
    end

    initial begin
        bus.i_fifo_empty = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            bus.i_fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Monitor: compares each accepted beat against the scoreboard, checks stream stability.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    n_vec++;
                    if (!bus.o_valid || bus.o_data !== hold_data || bus.o_last !== hold_last
`ifdef FIFO_RD_PACKER_FLUSH_EN
                        || bus.o_keep !== hold_keep
`endif
                    ) begin
                        n_bad++;
                        $display("FAIL stall_stable: got valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                                 bus.o_valid, bus.o_data, bus.o_last, hold_data, hold_last);
                    end
                end
                if (bus.o_valid && bus.i_ready) begin
                    n_vec++;
                    acc_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_beat: got data=%h last=%b, required no beat",
                                 bus.o_data, bus.o_last);
                    end else begin
                        mon_b = exp_q.pop_front();
                        if (bus.o_data !== mon_b.data || bus.o_last !== mon_b.last
`ifdef FIFO_RD_PACKER_FLUSH_EN
                            || bus.o_keep !== mon_b.keep
`endif
                        ) begin
                            n_bad++;
`ifdef FIFO_RD_PACKER_FLUSH_EN
                            $display("FAIL beat: got data=%h keep=%h last=%b, required data=%h keep=%h last=%b",
                                     bus.o_data, bus.o_keep, bus.o_last, mon_b.data, mon_b.keep, mon_b.last);
`else
                            $display("FAIL beat: got data=%h last=%b, required data=%h last=%b",
                                     bus.o_data, bus.o_last, mon_b.data, mon_b.last);
`endif
                        end
                    end
                end
                if (bus.o_fifo_rden && bus.i_fifo_empty) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL rden_empty: got rden=1 while empty, required 0");
                end
                hold_v    = bus.o_valid && !bus.i_ready;
                hold_data = bus.o_data;
                hold_last = bus.o_last;
`ifdef FIFO_RD_PACKER_FLUSH_EN
                hold_keep = bus.o_keep;
`else
                hold_keep = '1;
`endif
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_vec++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
    endtask

    task automatic expect_beat(input logic [BEAT_W-1:0] d, input logic [PN-1:0] k, input logic l);
        beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        exp_q.push_back(b);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check({name, "_drain_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic reset_and_check(input string name);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check({name, "_valid"}, {31'b0, bus.o_valid}, 0);
        check({name, "_data"}, bus.o_data, 0);
        check({name, "_last"}, {31'b0, bus.o_last}, 0);
        check({name, "_rden"}, {31'b0, bus.o_fifo_rden}, 0);
`ifdef FIFO_RD_PACKER_FLUSH_EN
        check({name, "_keep"}, {28'b0, bus.o_keep}, 0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.i_ready = 1'b0;
`ifdef FIFO_RD_PACKER_FLUSH_EN
        bus.i_flush = 1'b0;
`endif
        #1;
        check("por_valid", {31'b0, bus.o_valid}, 0);
        check("por_data", bus.o_data, 0);
        check("por_rden", {31'b0, bus.o_fifo_rden}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: eight words, ready held high; beats five cycles apart (one rden bubble each)
        @(negedge clk);
        bus.i_ready = 1'b1;
        acc_cyc.delete();
        for (int i = 1; i <= 8; i++) push_word(i[7:0]);
        expect_beat(32'h04030201, 4'hF, 1'b0);
        expect_beat(32'h08070605, 4'hF, 1'b0);
        wait_drain("t1");
        if (acc_cyc.size() >= 2) check("t1_beat_spacing", acc_cyc[1] - acc_cyc[0], PN + 1);
        else check("t1_beat_count", acc_cyc.size(), 2);

        // 2: twelve words with downstream stalled
        bus.i_ready = 1'b0;
        for (int i = 8'h11; i <= 8'h1C; i++) push_word(i[7:0]);
        expect_beat(32'h14131211, 4'hF, 1'b0);
        expect_beat(32'h18171615, 4'hF, 1'b0);
        expect_beat(32'h1C1B1A19, 4'hF, 1'b0);
        repeat (30) @(negedge clk);
        #2;
        check("t2_valid_held", {31'b0, bus.o_valid}, 1);
        check("t2_data_held", bus.o_data, 32'h14131211);
        check("t2_rden_stopped", {31'b0, bus.o_fifo_rden}, 0);
        check("t2_fifo_left", fifo_q.size(), 4);
        @(negedge clk);
        bus.i_ready = 1'b1;
        wait_drain("t2");

        // 4: FIFO runs dry mid-pack
        push_word(8'h01);
        push_word(8'h02);
        repeat (10) @(negedge clk);
        #2;
        check("t4_valid_idle", {31'b0, bus.o_valid}, 0);
        check("t4_rden_idle", {31'b0, bus.o_fifo_rden}, 0);
        @(negedge clk);
        push_word(8'h03);
        push_word(8'h04);
        expect_beat(32'h04030201, 4'hF, 1'b0);
        wait_drain("t4");

        // 5: reset mid-pack loses the partial words
        push_word(8'h31);
        push_word(8'h32);
        push_word(8'h33);
        repeat (10) @(negedge clk);
        reset_and_check("t5_reset");
        for (int i = 8'hA1; i <= 8'hA4; i++) push_word(i[7:0]);
        expect_beat(32'hA4A3A2A1, 4'hF, 1'b0);
        wait_drain("t5");

        // 3: 64 beats from a fresh frame; last on beats 16, 32, 48, 64
        reset_and_check("t3_reset");
        for (int i = 0; i < 256; i++) push_word(i[7:0]);
        for (int b = 0; b < 64; b++) begin
            logic [7:0] w0;
            w0 = 8'(b * 4);
            expect_beat({w0 + 8'd3, w0 + 8'd2, w0 + 8'd1, w0}, 4'hF, (b % BL) == BL - 1);
        end
        wait_drain("t3");

`ifdef FIFO_RD_PACKER_FLUSH_EN
        // 6: six words then flush -> one full beat, one zero-padded last beat
        for (int i = 1; i <= 6; i++) push_word(i[7:0]);
        expect_beat(32'h04030201, 4'hF, 1'b0);
        expect_beat(32'h00000605, 4'h3, 1'b1);
        repeat (15) @(negedge clk);
        bus.i_flush = 1'b1;
        @(negedge clk);
        bus.i_flush = 1'b0;
        wait_drain("t6");

        // flush with nothing pending marks the next beat last
        @(negedge clk);
        bus.i_flush = 1'b1;
        @(negedge clk);
        bus.i_flush = 1'b0;
        for (int i = 8'h41; i <= 8'h44; i++) push_word(i[7:0]);
        for (int i = 8'h51; i <= 8'h54; i++) push_word(i[7:0]);
        expect_beat(32'h44434241, 4'hF, 1'b1);
        expect_beat(32'h54535251, 4'hF, 1'b0);
        wait_drain("t6_idle_flush");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
